// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared state encoding and direction constants for the up/down sweep controller.
package sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UP,
        S_DOWN
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_N       = 4;
    localparam int DEFAULT_SWEEP_W = 8;

endpackage

// File: rtl/updown_sweep_ctrl_step_core.sv
// N-bit up/down step register: load wins over stepping, en=0 holds the value.
module updown_step_core
    import sweep_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer (lo -> hi -> lo, repeated) driving an up/down step core.
// Define SWEEP_PAUSE_EN to add the pause input that freezes a running sweep.
module updown_sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int SWEEP_W = DEFAULT_SWEEP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       lo,
    input  logic [N-1:0]       hi,
    input  logic [SWEEP_W-1:0] num_sweeps,
`ifdef SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    output logic [N-1:0]       count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SWEEP_W-1:0] sweep_cnt
);

    state_t             state_q, state_d;
    logic [N-1:0]       lo_q, lo_d;
    logic [N-1:0]       hi_q, hi_d;
    logic [SWEEP_W-1:0] num_q, num_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               core_load;
    logic [N-1:0]       core_val;
    logic               core_en;
    logic               core_dir;
    logic [N-1:0]       core_count;

    logic               paused;
    logic               req_ok;
    logic [SWEEP_W-1:0] sweep_next;

`ifdef SWEEP_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign req_ok     = (lo < hi) && (num_sweeps != '0);
    assign sweep_next = sweep_cnt_q + 1'b1;

    updown_step_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_val),
        .en       (core_en),
        .dir      (core_dir),
        .count    (core_count)
    );

    // Bound checks are pure equality, so hi = 2^N-1 and lo = 0 never overflow.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        num_d       = num_q;
        sweep_cnt_d = sweep_cnt_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        core_load   = 1'b0;
        core_val    = lo_q;
        core_en     = 1'b0;
        core_dir    = DIR_UP;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        lo_d        = lo;
                        hi_d        = hi;
                        num_d       = num_sweeps;
                        sweep_cnt_d = '0;
                        dir_d       = DIR_UP;
                        core_load   = 1'b1;
                        core_val    = lo;
                        state_d     = S_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_UP: begin
                if (!paused) begin
                    core_en = 1'b1;
                    if (core_count == hi_q) begin
                        core_dir = DIR_DOWN;
                        dir_d    = DIR_DOWN;
                        state_d  = S_DOWN;
                    end else begin
                        core_dir = DIR_UP;
                    end
                end
            end
            S_DOWN: begin
                if (!paused) begin
                    if (core_count != lo_q) begin
                        core_en  = 1'b1;
                        core_dir = DIR_DOWN;
                    end else begin
                        sweep_cnt_d = sweep_next;
                        dir_d       = DIR_UP;
                        if (sweep_next == num_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            // Later sweeps start at lo+1 so lo is not shown twice.
                            core_load = 1'b1;
                            core_val  = lo_q + 1'b1;
                            state_d   = S_UP;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            num_q       <= '0;
            sweep_cnt_q <= '0;
            dir_q       <= DIR_UP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            num_q       <= num_d;
            sweep_cnt_q <= sweep_cnt_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign count     = core_count;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_cnt_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the expected sweep trace.
module tb_updown_sweep_ctrl;

    localparam int N  = 4;
    localparam int SW = 8;

    typedef struct packed {
        logic [N-1:0]  c;
        logic          d;
        logic [SW-1:0] s;
    } step_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [SW-1:0] num_sweeps;
    logic          pause;
    logic [N-1:0]  count;
    logic          dir;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW-1:0] sweep_cnt;

    int checks;
    int errors;

    // Reference model: the visible outputs plus the queue of future busy-cycle outputs.
    step_t         exp_q[$];
    logic [N-1:0]  m_count;
    logic          m_dir;
    logic          m_busy;
    logic          m_done;
    logic          m_err;
    logic [SW-1:0] m_sweep;
    logic [SW-1:0] m_num;

    updown_sweep_ctrl #(
        .N       (N),
        .SWEEP_W (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lo         (lo),
        .hi         (hi),
        .num_sweeps (num_sweeps),
`ifdef SWEEP_PAUSE_EN
        .pause      (pause),
`endif
        .count      (count),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sweep_cnt  (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [N-1:0] l, input logic [N-1:0] h,
                                 input logic [SW-1:0] n, input logic r, input logic p);
        start      = s;
        lo         = l;
        hi         = h;
        num_sweeps = n;
        rst        = r;
        pause      = p;
    endtask

    // Expected trace of a whole run: first triangle from lo, later ones from lo+1.
    task automatic buildRun(input int l, input int h, input int n);
        step_t t;
        exp_q.delete();
        for (int sw = 0; sw < n; sw++) begin
            for (int v = (sw == 0) ? l : l + 1; v <= h; v++) begin
                t.c = v[N-1:0];
                t.d = 1'b1;
                t.s = sw[SW-1:0];
                exp_q.push_back(t);
            end
            for (int v = h - 1; v >= l; v--) begin
                t.c = v[N-1:0];
                t.d = 1'b0;
                t.s = sw[SW-1:0];
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic updateModel();
        step_t t;
        logic  held;
        held = 1'b0;
`ifdef SWEEP_PAUSE_EN
        held = pause;
`endif
        if (rst) begin
            exp_q.delete();
            m_count = '0;
            m_dir   = 1'b1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_sweep = '0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!held) begin
                if (exp_q.size() > 0) begin
                    t       = exp_q.pop_front();
                    m_count = t.c;
                    m_dir   = t.d;
                    m_sweep = t.s;
                end else begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_dir   = 1'b1;
                    m_sweep = m_num;
                end
            end
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (start) begin
                if (lo < hi && num_sweeps != 0) begin
                    m_num = num_sweeps;
                    buildRun(int'(lo), int'(hi), int'(num_sweeps));
                    t       = exp_q.pop_front();
                    m_count = t.c;
                    m_dir   = t.d;
                    m_sweep = t.s;
                    m_busy  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        updateModel();
        #1;
        checkOutput("count", 32'(count), 32'(m_count));
        checkOutput("dir", 32'(dir), 32'(m_dir));
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("sweep_cnt", 32'(sweep_cnt), 32'(m_sweep));
    endtask

    task automatic runUntilDone(input int limit);
        int n;
        n = 0;
        while (!m_done && n < limit) begin
            stepCycle();
            n++;
        end
        checkOutput("run_reached_done", 32'(m_done), 32'd1);
    endtask

    int peak;
    int waited;

    initial begin
        checks = 0;
        errors = 0;
        exp_q.delete();
        m_count = '0; m_dir = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_sweep = '0; m_num = '0;

        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("reset_dir", 32'(dir), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        stepCycle();

        // Single sweep 2..5..2 with done pulse afterwards.
        applyStimulus(1'b1, 4'd2, 4'd5, 8'd1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t1_first_count", 32'(count), 32'd2);
        applyStimulus(1'b0, 4'd2, 4'd5, 8'd1, 1'b0, 1'b0);
        runUntilDone(40);
        checkOutput("t1_done_busy", 32'(busy), 32'd0);
        checkOutput("t1_done_sweeps", 32'(sweep_cnt), 32'd1);
        stepCycle();
        checkOutput("t1_done_one_cycle", 32'(done), 32'd0);

        // Full-range run: peak must be 15 and the count must never wrap.
        applyStimulus(1'b1, 4'd0, 4'd15, 8'd2, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        peak = 0;
        waited = 0;
        while (!m_done && waited < 200) begin
            stepCycle();
            if (int'(count) > peak) peak = int'(count);
            waited++;
        end
        checkOutput("t2_peak", 32'(peak), 32'd15);
        checkOutput("t2_sweeps", 32'(sweep_cnt), 32'd2);
        stepCycle();

        // Rejected requests: equal bounds, inverted bounds, zero sweeps.
        applyStimulus(1'b1, 4'd7, 4'd7, 8'd1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t3_err_eq", 32'(err), 32'd1);
        applyStimulus(1'b1, 4'd9, 4'd3, 8'd1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 4'd2, 4'd5, 8'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t3_err_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t3_err_pulse", 32'(err), 32'd0);

        // Reset at count 3 during the second sweep: immediate abort, no done.
        applyStimulus(1'b1, 4'd1, 4'd4, 8'd3, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        waited = 0;
        while (!(m_sweep == 8'd1 && m_count == 4'd3) && waited < 60) begin
            stepCycle();
            waited++;
        end
        checkOutput("t4_reached_point", 32'(count), 32'd3);
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("t4_rst_count", 32'(count), 32'd0);
        checkOutput("t4_rst_done", 32'(done), 32'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t4_no_done", 32'(done), 32'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        applyStimulus(1'b1, 4'd3, 4'd6, 8'd2, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 4'd0, 4'd9, 8'd1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd9, 8'd1, 1'b0, 1'b0);
        peak = 0;
        waited = 0;
        while (!m_done && waited < 60) begin
            stepCycle();
            if (int'(count) > peak) peak = int'(count);
            waited++;
        end
        checkOutput("t5_orig_peak", 32'(peak), 32'd6);
        checkOutput("t5_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 4'd1, 4'd3, 8'd1, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t5_restart_busy", 32'(busy), 32'd1);
        checkOutput("t5_restart_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        runUntilDone(40);
        stepCycle();

`ifdef SWEEP_PAUSE_EN
        // Pause for three cycles at count 4 on the way up.
        applyStimulus(1'b1, 4'd2, 4'd8, 8'd1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        waited = 0;
        while (!(m_count == 4'd4 && m_dir) && waited < 20) begin
            stepCycle();
            waited++;
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("t6_pause_hold", 32'(count), 32'd4);
            checkOutput("t6_pause_busy", 32'(busy), 32'd1);
        end
        applyStimulus(1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("t6_resume", 32'(count), 32'd5);
        runUntilDone(40);
        stepCycle();
`endif

        // Random traffic, occasional resets and (when present) pauses.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 5) == 0,
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          8'($urandom_range(0, 3)),
                          $urandom_range(0, 99) == 0,
                          $urandom_range(0, 4) == 0);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
